// File: rtl/mem_arb_pkg.sv
// Shared types for the main_mem line arbiter: FSM states, port ids and port count.
package mem_arb_pkg;

  localparam int N_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  typedef logic port_id_t;
  localparam port_id_t ICACHE = 1'b0;
  localparam port_id_t DCACHE = 1'b1;

  function automatic logic [N_PORTS-1:0] port_onehot(input port_id_t p);
    logic [N_PORTS-1:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection for the line arbiter.
// MEM_LINE_ARB_RR_EN selects round-robin; otherwise D-cache has fixed priority.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic [N_PORTS-1:0] req_i,
  input  port_id_t           rr_i,
  output port_id_t           winner_o,
  output logic               any_req_o,
  output port_id_t           rr_next_o
);

  assign any_req_o = |req_i;

`ifdef MEM_LINE_ARB_RR_EN
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (latch).
    winner_o  = ICACHE;
    rr_next_o = ICACHE;
    if (req_i[rr_i]) winner_o = rr_i;
    else             winner_o = ~rr_i;
    rr_next_o = ~winner_o;
  end
`else
  logic unused_rr;
  assign unused_rr = rr_i;

  always_comb begin
    winner_o  = ICACHE;
    rr_next_o = ICACHE;
    if (req_i[DCACHE]) winner_o = DCACHE;
  end
`endif

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares the line-wide main_mem port between I-cache (port 0) and D-cache (port 1).
// Arbitration: MEM_LINE_ARB_RR_EN defined -> round-robin, undefined -> fixed D-cache priority.
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int LINE_ADDR_LEN = 2,
  parameter  int ADDR_LEN      = 7,
  localparam int LINE_SIZE     = 1 << LINE_ADDR_LEN
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_PORTS-1:0]                      s_rd_req,
  input  logic [N_PORTS-1:0]                      s_wr_req,
  input  logic [N_PORTS-1:0][ADDR_LEN-1:0]        s_addr,
  input  logic [N_PORTS-1:0][LINE_SIZE-1:0][31:0] s_wr_line,
  output logic [N_PORTS-1:0]                      s_gnt,
  output logic [LINE_SIZE-1:0][31:0]              s_rd_line,
  output logic                                    m_rd_req,
  output logic                                    m_wr_req,
  output logic [ADDR_LEN-1:0]                     m_addr,
  output logic [LINE_SIZE-1:0][31:0]              m_wr_line,
  input  logic [LINE_SIZE-1:0][31:0]              m_rd_line,
  input  logic                                    m_gnt
);

  arb_state_e                 state_q;
  port_id_t                   owner_q;
  port_id_t                   rr_q;
  port_id_t                   winner;
  port_id_t                   rr_d;
  logic                       any_req;
  logic [N_PORTS-1:0]         gnt_q;
  logic                       m_rd_req_q;
  logic                       m_wr_req_q;
  logic [ADDR_LEN-1:0]        addr_q;
  logic [LINE_SIZE-1:0][31:0] wr_line_q;
  logic [LINE_SIZE-1:0][31:0] rd_line_q;

  mem_arb_picker u_picker (
    .req_i     (s_rd_req | s_wr_req),
    .rr_i      (rr_q),
    .winner_o  (winner),
    .any_req_o (any_req),
    .rr_next_o (rr_d)
  );

  // NOTE: all state here uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= ICACHE;
      rr_q       <= ICACHE;
      gnt_q      <= '0;
      m_rd_req_q <= 1'b0;
      m_wr_req_q <= 1'b0;
      addr_q     <= '0;
      // NOTE: the line registers are reset as well; both lines are visible at the ports right after reset.
      wr_line_q  <= '0;
      rd_line_q  <= '0;
    end else begin
      gnt_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q    <= winner;
            rr_q       <= rr_d;
            addr_q     <= s_addr[winner];
            wr_line_q  <= s_wr_line[winner];
            m_wr_req_q <= s_wr_req[winner];
            m_rd_req_q <= ~s_wr_req[winner];
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          // Completion is unconditional once issued: a requester dropping out does not abort.
          if (m_gnt) begin
            if (m_rd_req_q) rd_line_q <= m_rd_line;
            m_rd_req_q <= 1'b0;
            m_wr_req_q <= 1'b0;
            gnt_q      <= port_onehot(owner_q);
            state_q    <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_gnt     = gnt_q;
  assign s_rd_line = rd_line_q;
  assign m_rd_req  = m_rd_req_q;
  assign m_wr_req  = m_wr_req_q;
  assign m_addr    = addr_q;
  assign m_wr_line = wr_line_q;

  a_gnt_onehot: assert property (@(posedge clk) $onehot0(s_gnt));
  a_dir_excl:   assert property (@(posedge clk) !(m_rd_req && m_wr_req));
  a_req_steady: assert property (@(posedge clk) disable iff (rst)
    ((m_rd_req || m_wr_req) && $past(m_rd_req || m_wr_req)) |-> ($stable(m_addr) && $stable(m_wr_line)));

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench for mem_line_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_line_arbiter;
  import mem_arb_pkg::*;

  localparam int LINE_ADDR_LEN = 2;
  localparam int ADDR_LEN      = 7;
  localparam int LINE_SIZE     = 4;

  typedef logic [LINE_SIZE-1:0][31:0] line_t;
  typedef logic [ADDR_LEN-1:0]        addr_t;

  logic                                    clk = 1'b0;
  logic                                    rst = 1'b1;
  logic [N_PORTS-1:0]                      s_rd_req = '0;
  logic [N_PORTS-1:0]                      s_wr_req = '0;
  logic [N_PORTS-1:0][ADDR_LEN-1:0]        s_addr = '0;
  logic [N_PORTS-1:0][LINE_SIZE-1:0][31:0] s_wr_line = '0;
  logic [N_PORTS-1:0]                      s_gnt;
  line_t                                   s_rd_line;
  logic                                    m_rd_req;
  logic                                    m_wr_req;
  addr_t                                   m_addr;
  line_t                                   m_wr_line;
  line_t                                   m_rd_line = '0;
  logic                                    m_gnt = 1'b0;

  always #5 clk = ~clk;

  mem_line_arbiter #(.LINE_ADDR_LEN(LINE_ADDR_LEN), .ADDR_LEN(ADDR_LEN)) dut (
    .clk(clk), .rst(rst),
    .s_rd_req(s_rd_req), .s_wr_req(s_wr_req), .s_addr(s_addr), .s_wr_line(s_wr_line),
    .s_gnt(s_gnt), .s_rd_line(s_rd_line),
    .m_rd_req(m_rd_req), .m_wr_req(m_wr_req), .m_addr(m_addr), .m_wr_line(m_wr_line),
    .m_rd_line(m_rd_line), .m_gnt(m_gnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Main memory model: fixed or random wait, grant pulse, backing store.
  line_t mem [128];
  int    mem_wait = 0;
  int    mem_cnt  = 0;
  bit    mem_rand = 1'b0;

  // Cache agents.
  bit hold_extra  [N_PORTS];
  bit drop_next   [N_PORTS];
  bit auto_repost [N_PORTS];
  bit rand_mode = 1'b0;
  int gnt_log [$];

  // Reference model: one in-flight transaction record plus the visible output values.
  bit       tx_live;
  bit       tx_mem_done;
  port_id_t tx_port;
  bit       tx_wr;
  port_id_t md_rr;
  logic     e_mrd, e_mwr;
  addr_t    e_addr;
  line_t    e_wline, e_rline;
  logic [N_PORTS-1:0] e_sgnt;

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LINE_SIZE; i++) l[i] = $urandom;
    return l;
  endfunction

  task automatic post(input int p, input bit rd, input bit wr, input addr_t a, input line_t l);
    s_rd_req[p]  = rd;
    s_wr_req[p]  = wr;
    s_addr[p]    = a;
    s_wr_line[p] = l;
  endtask

  task automatic clear_req(input int p);
    s_rd_req[p]  = 1'b0;
    s_wr_req[p]  = 1'b0;
    s_addr[p]    = addr_t'($urandom);
    s_wr_line[p] = rand_line();
  endtask

  task automatic post_random(input int p);
    int kind;
    kind = $urandom_range(0, 2);
    post(p, kind != 1, kind != 0, addr_t'($urandom_range(0, 15)), rand_line());
    hold_extra[p] = $urandom_range(0, 1) == 1;
  endtask

  // Model update at the clock edge, from the inputs the DUT is sampling.
  task automatic model_edge();
    logic [N_PORTS-1:0] reqs;
    port_id_t w;
    if (rst) begin
      tx_live = 0; tx_mem_done = 0; md_rr = ICACHE;
      e_mrd = 0; e_mwr = 0; e_addr = '0; e_wline = '0; e_rline = '0; e_sgnt = '0;
    end else begin
      e_sgnt = '0;
      if (tx_live && !tx_mem_done) begin
        if (m_gnt) begin
          tx_mem_done = 1;
          e_mrd = 0; e_mwr = 0;
          e_sgnt[tx_port] = 1'b1;
          if (!tx_wr) e_rline = m_rd_line;
        end
      end else if (tx_live) begin
        tx_live = 0;
      end else begin
        reqs = s_rd_req | s_wr_req;
        if (reqs != '0) begin
`ifdef MEM_LINE_ARB_RR_EN
          w = reqs[md_rr] ? md_rr : ~md_rr;
          md_rr = ~w;
`else
          w = reqs[DCACHE] ? DCACHE : ICACHE;
`endif
          tx_live = 1; tx_mem_done = 0; tx_port = w; tx_wr = s_wr_req[w];
          e_mwr = tx_wr; e_mrd = !tx_wr;
          e_addr = s_addr[w]; e_wline = s_wr_line[w];
        end
      end
    end
  endtask

  task automatic drive_memory();
    if ((m_rd_req || m_wr_req) && !rst) begin
      if (mem_cnt >= mem_wait) begin
        m_gnt = 1'b1;
        if (m_rd_req) m_rd_line = mem[m_addr];
        else begin
          m_rd_line = rand_line();
          mem[m_addr] = m_wr_line;
        end
        mem_cnt = 0;
        if (mem_rand) mem_wait = $urandom_range(0, 3);
      end else begin
        m_gnt = 1'b0;
        mem_cnt++;
        m_rd_line = rand_line();
      end
    end else begin
      m_gnt = 1'b0;
      mem_cnt = 0;
      m_rd_line = rand_line();
    end
  endtask

  task automatic drive_agents();
    for (int p = 0; p < N_PORTS; p++) begin
      if (drop_next[p]) begin
        clear_req(p);
        drop_next[p] = 1'b0;
      end
      if (s_gnt[p]) begin
        if (auto_repost[p])     post_random(p);
        else if (hold_extra[p]) drop_next[p] = 1'b1;
        else                    clear_req(p);
      end else if (rand_mode && !drop_next[p]) begin
        if (!(s_rd_req[p] || s_wr_req[p])) begin
          if ($urandom_range(0, 3) == 0) post_random(p);
        end else if ($urandom_range(0, 63) == 0) begin
          clear_req(p);
        end
      end
    end
  endtask

  // One clock: model at the edge, compare 1 time unit later, then drive the next inputs.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("s_gnt",     128'(s_gnt),     128'(e_sgnt));
    check("m_rd_req",  128'(m_rd_req),  128'(e_mrd));
    check("m_wr_req",  128'(m_wr_req),  128'(e_mwr));
    check("m_addr",    128'(m_addr),    128'(e_addr));
    check("m_wr_line", m_wr_line,       e_wline);
    check("s_rd_line", s_rd_line,       e_rline);
    check("s_gnt_excl", 128'($onehot0(s_gnt)), 128'(1));
    for (int p = 0; p < N_PORTS; p++) if (s_gnt[p]) gnt_log.push_back(p);
    drive_memory();
    drive_agents();
  endtask

  task automatic wait_grants(input int n, input int budget);
    int target;
    int k;
    target = gnt_log.size() + n;
    k = 0;
    while (gnt_log.size() < target && k < budget) begin
      step();
      k++;
    end
    check("grant_wait", 128'(gnt_log.size() >= target), 128'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < N_PORTS; p++) begin
      clear_req(p);
      drop_next[p] = 1'b0;
    end
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    line_t l1, w2;
    int    hi, k;
    bit    seen_wr;
    int    exp4 [4];

    for (int i = 0; i < 128; i++) mem[i] = rand_line();
    for (int p = 0; p < N_PORTS; p++) begin
      hold_extra[p] = 0; drop_next[p] = 0; auto_repost[p] = 0;
    end
    l1 = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    w2 = {32'd4, 32'd3, 32'd2, 32'd1};
    mem[7'h15] = l1;

    // Reset state.
    do_reset();
    check("reset_s_gnt",     128'(s_gnt),    128'(0));
    check("reset_m_rd_req",  128'(m_rd_req), 128'(0));
    check("reset_m_wr_req",  128'(m_wr_req), 128'(0));
    check("reset_m_addr",    128'(m_addr),   128'(0));
    check("reset_m_wr_line", m_wr_line,      128'(0));
    check("reset_s_rd_line", s_rd_line,      128'(0));

    // Lone read with a 4-cycle memory.
    mem_wait = 3;
    gnt_log.delete();
    post(0, 1'b1, 1'b0, 7'h15, rand_line());
    hi = 0; k = 0;
    while (gnt_log.size() == 0 && k < 50) begin
      step();
      k++;
      if (m_rd_req) begin
        hi++;
        if (hi == 1) check("t1_m_addr", 128'(m_addr), 128'(7'h15));
      end
    end
    check("t1_rd_cycles", 128'(hi), 128'(4));
    if (gnt_log.size() > 0) check("t1_owner", 128'(gnt_log[0]), 128'(0));
    check("t1_rd_line", s_rd_line, l1);
    step();
    check("t1_single_pulse", 128'(s_gnt), 128'(0));

    // Lone write, then read it back.
    mem_wait = 1;
    gnt_log.delete();
    post(1, 1'b0, 1'b1, 7'h03, w2);
    seen_wr = 0; k = 0;
    while (gnt_log.size() == 0 && k < 50) begin
      step();
      k++;
      if (m_wr_req && !seen_wr) begin
        seen_wr = 1;
        check("t2_m_addr", 128'(m_addr), 128'(7'h03));
        check("t2_m_wr_line", m_wr_line, w2);
      end
    end
    check("t2_saw_wr_req", 128'(seen_wr), 128'(1));
    if (gnt_log.size() > 0) check("t2_owner", 128'(gnt_log[0]), 128'(1));
    check("t2_rd_line_kept", s_rd_line, l1);
    repeat (2) step();
    post(0, 1'b1, 1'b0, 7'h03, rand_line());
    wait_grants(1, 30);
    check("t2_reread", s_rd_line, w2);

    // Simultaneous reads.
    mem_wait = 0;
    repeat (2) step();
    gnt_log.delete();
    post(0, 1'b1, 1'b0, 7'h08, rand_line());
    post(1, 1'b1, 1'b0, 7'h09, rand_line());
    wait_grants(2, 40);
    if (gnt_log.size() >= 2) begin
      check("t3_distinct", 128'(gnt_log[0] != gnt_log[1]), 128'(1));
`ifndef MEM_LINE_ARB_RR_EN
      check("t3_first_dcache", 128'(gnt_log[0]), 128'(1));
`endif
    end

    // Both ports requesting continuously for 4 transactions, from a fresh reset.
    do_reset();
`ifdef MEM_LINE_ARB_RR_EN
    exp4 = '{0, 1, 0, 1};
`else
    exp4 = '{1, 1, 1, 1};
`endif
    gnt_log.delete();
    auto_repost[0] = 1; auto_repost[1] = 1;
    post_random(0);
    post_random(1);
    hold_extra[0] = 0; hold_extra[1] = 0;
    wait_grants(4, 80);
    auto_repost[0] = 0; auto_repost[1] = 0;
    hold_extra[0] = 0; hold_extra[1] = 0;
    for (int i = 0; i < 4; i++)
      if (gnt_log.size() > i) check("t4_order", 128'(gnt_log[i]), 128'(exp4[i]));
    clear_req(0); clear_req(1);
    repeat (8) step();

    // Owner keeps its request high through DONE.
    gnt_log.delete();
    post(0, 1'b1, 1'b0, 7'h11, rand_line());
    post(1, 1'b1, 1'b0, 7'h12, rand_line());
    hold_extra[0] = 1; hold_extra[1] = 1;
    wait_grants(2, 40);
    repeat (6) step();
    hold_extra[0] = 0; hold_extra[1] = 0;
    check("t5_grant_count", 128'(gnt_log.size()), 128'(2));
    if (gnt_log.size() >= 2) check("t5_distinct", 128'(gnt_log[0] != gnt_log[1]), 128'(1));

    // Reset while a read is being issued.
    mem_wait = 20;
    post(0, 1'b1, 1'b0, 7'h05, rand_line());
    k = 0;
    while (!m_rd_req && k < 10) begin
      step();
      k++;
    end
    check("t6_in_issue", 128'(m_rd_req), 128'(1));
    rst = 1'b1;
    clear_req(0); clear_req(1);
    step();
    check("t6_rd_req_dropped", 128'(m_rd_req), 128'(0));
    check("t6_no_gnt", 128'(s_gnt), 128'(0));
    rst = 1'b0;
    mem_wait = 0;
    gnt_log.delete();
    post(0, 1'b1, 1'b0, 7'h05, rand_line());
    wait_grants(1, 20);
    if (gnt_log.size() > 0) check("t6_fresh_owner", 128'(gnt_log[0]), 128'(0));
    check("t6_fresh_line", s_rd_line, mem[7'h05]);

    // Randomized traffic with random memory latency and occasional resets.
    mem_rand = 1;
    rand_mode = 1;
    repeat (3000) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        for (int p = 0; p < N_PORTS; p++) begin
          clear_req(p);
          drop_next[p] = 1'b0;
        end
      end else begin
        rst = 1'b0;
      end
      step();
    end
    rand_mode = 0;
    rst = 1'b0;
    clear_req(0); clear_req(1);
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
